// File: rtl/srq_beat_serializer.sv
// Width down-converter: pops IN_WIDTH-bit queue entries and streams them as OUT_WIDTH-bit beats.
// Optional even parity on each beat when SER_PARITY_EN is defined; otherwise beat_parity is tied to 0.
module srq_beat_serializer #(
   parameter int IN_WIDTH  = 1024,
   parameter int OUT_WIDTH = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 q_out_valid,
   input  logic [IN_WIDTH-1:0]  q_data,
   output logic                 q_pop,
   output logic                 beat_valid,
   input  logic                 beat_ready,
   output logic [OUT_WIDTH-1:0] beat_data,
   output logic                 beat_last,
   output logic                 beat_parity,
   output logic                 busy
);

   localparam int BEATS = IN_WIDTH / OUT_WIDTH;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t                          state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [IN_WIDTH-1:0]             hold_q, hold_d;
   logic [BEATS-1:0][OUT_WIDTH-1:0] slices;
   logic                            beat_hs;
   logic                            last_hs;

   // Beat 0 is the least-significant slice of the held entry.
   assign slices     = hold_q;
   assign beat_data  = slices[cnt_q];
   assign beat_valid = (state_q == SEND);
   assign busy       = (state_q == SEND);
   assign beat_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
   assign beat_hs    = beat_valid && beat_ready;
   assign last_hs    = beat_hs && beat_last;
   assign q_pop      = rst && q_out_valid && ((state_q == IDLE) || last_hs);

`ifdef SER_PARITY_EN
   assign beat_parity = ^beat_data;
`else
   assign beat_parity = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (q_pop) begin
               hold_d  = q_data;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            // Reloading on the last handshake keeps consecutive bursts gap-free.
            if (last_hs) begin
               cnt_d = '0;
               if (q_pop) begin
                  hold_d = q_data;
               end else begin
                  state_d = IDLE;
               end
            end else if (beat_hs) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

endmodule
